load_store_unit: RTL and testbench
==================================

# load_store_unit

Multi-cycle load/store unit downstream of the ALU. It takes the ALU result `y` as the effective byte address and performs one data-memory access over a req/gnt/rvalid handshake. While the access is in flight it stalls the core. For loads it returns lane-extracted, sign/zero-extended data for register writeback.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum number of cycles spent in REQ+WAIT before the access is aborted with `fault`. Legal range 2..65535.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  memory instruction present in execute; sampled only in IDLE.
- `op`  in  `MemOp::t_e` (3)  LB, LH, LW, LBU, LHU, SB, SH, SW.
- `addr`  in  32  effective byte address (ALU `y`).
- `wdata`  in  32  store data (rs2).
- `stall`  out  1  hold PC and pipeline state.
- `done`  out  1  one-cycle retire strobe.
- `fault`  out  1  valid with `done`; misaligned access or timeout.
- `rdata`  out  32  load result; valid with `done` for loads.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  request is a store.
- `mem_addr`  out  32  word address, i.e. `{addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data; 0 for loads.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid or store acknowledged. Asserts no earlier than the cycle after `mem_gnt`.
- `mem_rdata`  in  32  read data.

## Operation
FSM states: IDLE, REQ, WAIT, DONE.

- **IDLE:** on `start`, latch `op`, `addr` and `wdata`.
  - If misaligned (H: `addr[0]`; W: `addr[1:0]!=0`), go to DONE with fault set; no memory access.
  - Otherwise go to REQ.
- **REQ:** `mem_req`=1, with all `mem_*` driven from latched values and stable until the grant. On `mem_gnt` go to WAIT.
- **WAIT:** on `mem_rvalid` go to DONE.
  - Loads capture extracted data into `rdata`.
  - Stores: `rvalid` is the write acknowledge; `mem_rdata` is ignored.
- **DONE:** `done`=1 for one cycle, then unconditionally go to IDLE. `start` in DONE is ignored; the next instruction starts from IDLE.
- **Timeout:** a counter clears on IDLE→REQ and increments each cycle in REQ/WAIT. If it reaches `TIMEOUT_CYCLES` without completion, go to DONE with fault. `rdata` is unchanged and `mem_req` drops.
- **Late `mem_rvalid`/`mem_gnt`** in IDLE/DONE: ignored.
- **Byte enables:**
  - B: `4'b0001<<addr[1:0]`
  - H: `4'b0011<<addr[1:0]`
  - W: `4'b1111`
- **Store data:**
  - SB: `wdata[7:0]` replicated ×4.
  - SH: `wdata[15:0]` replicated ×2.
  - SW: as-is.
- **Load extraction:** `mem_rdata >> (8*addr[1:0])`, then take the low 8/16/32 bits. Sign-extend for LB/LH, zero-extend for LBU/LHU.

## Timing
- **Stall:** `stall = (state==IDLE && start) || state==REQ || state==WAIT`. Combinational; deasserted in DONE.
- **`rdata`:** registered.
- **`fault`, `done`:** registered, decoded from state.
- **Minimum latency:** `gnt` in the first REQ cycle and `rvalid` the next cycle give 3 stall cycles, with `done` in the 4th cycle after `start`.
- **Misaligned:** 1 stall cycle, `done`+`fault` in the next cycle.
- **Reset values:** state=IDLE, counter=0. `stall` follows `start` (combinational). `mem_req`, `mem_we`, `done` and `fault` are 0; `mem_addr`, `mem_be`, `mem_wdata` and `rdata` are 0.
- **Reset mid-access:** immediate return to IDLE; `mem_req` drops asynchronously and the outstanding response is ignored.
- **Timeout boundary:** a `mem_rvalid` arriving in the same cycle the counter hits the limit counts as completion, not fault.

## Structure
- Package `Shared`:
  - `MemOp::t_e` (3-bit enum: LB=0, LH, LW, LBU, LHU, SB, SH, SW=7).
  - `LsuState::t_e`.
  - Helper predicates `is_store`/`size_of`.
- Sub-module `lsu_align`: combinational byte-enable generation, store lane replication and load extraction/extension, instantiated once.
- FSM, latches and counter live in `load_store_unit`.

## Test plan
1. **SW aligned:** `addr`=0x100, `wdata`=0xDEADBEEF, `gnt` immediate, `rvalid` +1. Expect `mem_be`=1111, `mem_we`=1, `mem_wdata`=0xDEADBEEF, `stall` for 3 cycles, then `done`=1 with `fault`=0.
2. **LB sign extension:** `addr`=0x103, `mem_rdata`=0x80112233. Expect `mem_be`=1000, `rdata`=0xFFFFFF80. LBU on the same address gives 0x00000080.
3. **SH at `addr`=0x2:** `wdata`=0x0000ABCD. Expect `mem_be`=1100, `mem_wdata`=0xABCDABCD.
4. **Misaligned:** LW at 0x101 or LH at 0x3. Expect no `mem_req`, 1 stall cycle, then `done`=`fault`=1.
5. **Timeout:** `TIMEOUT_CYCLES`=4 with `gnt` never asserted. Expect `mem_req` for 4 cycles, then `done`=`fault`=1 with `rdata` unchanged. A late `gnt` in IDLE is ignored.
6. **Reset during WAIT, then recovery:** deassert `rst_n` in WAIT. Expect `mem_req`=0 and all outputs at reset values. A subsequent LW with `gnt` delayed 2 cycles completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared types, state encodings and op predicates for the load/store unit
//   mem_op_e       : 3-bit memory operation (LB=0 .. SW=7)
//   ST_*           : FSM state encodings
//   SZ_*           : access size codes returned by size_of()
//   is_store()     : op writes memory
//   size_of()      : access size of an op
//   is_misaligned(): access crosses its natural alignment
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LBU = 3'd3,
    LHU = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } mem_op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic is_store(input mem_op_e op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  function automatic logic [1:0] size_of(input mem_op_e op);
    logic [1:0] sz;
    case (op)
      LB, LBU, SB: sz = SZ_B;
      LH, LHU, SH: sz = SZ_H;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] lo);
    logic [1:0] sz;
    sz = size_of(op);
    return ((sz == SZ_H) && lo[0]) || ((sz == SZ_W) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable generation, store lane replication and load extraction
//   op        in  latched memory operation
//   addr_lo   in  byte offset within the word
//   wdata     in  latched store data
//   mem_rdata in  raw read word from memory
//   be        out byte enables for the access
//   wdata_rep out store data replicated across lanes
//   load_data out extracted, sign/zero-extended load result
module lsu_align
  import load_store_unit_pkg::*;
(
  input  mem_op_e     op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  always_comb begin
    be = 4'b0000;
    case (size_of(op))
      SZ_B:    be = 4'b0001 << addr_lo;
      SZ_H:    be = 4'b0011 << addr_lo;
      default: be = 4'b1111;
    endcase
  end

  always_comb begin
    wdata_rep = wdata;
    case (size_of(op))
      SZ_B:    wdata_rep = {4{wdata[7:0]}};
      SZ_H:    wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // Selected lane lands in the low bits; extension then depends only on op.
  assign shifted = mem_rdata >> {addr_lo, 3'b000};

  always_comb begin
    load_data = shifted;
    case (op)
      LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     load_data = {24'h000000, shifted[7:0]};
      LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
      LHU:     load_data = {16'h0000, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit over a req/gnt/rvalid memory handshake
//   clk, rst_n     in  clock, asynchronous active-low reset
//   start,op       in  memory instruction present / operation
//   addr, wdata    in  effective byte address, store data
//   stall          out hold the pipeline while the access is in flight
//   done, fault    out retire strobe, misalign/timeout flag (valid with done)
//   rdata          out load result (valid with done for loads)
//   mem_req..mem_wdata out  request channel to data memory
//   mem_gnt, mem_rvalid, mem_rdata in  memory responses
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  mem_op_e     op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  // Counter value seen in the last allowed REQ/WAIT cycle.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  mem_op_e     op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [15:0] cnt_q;
  logic        fault_q;
  logic [31:0] rdata_q;

  logic [3:0]  be;
  logic [31:0] wdata_rep;
  logic [31:0] load_data;
  logic        req_active;

  lsu_align u_align (
    .op        (op_q),
    .addr_lo   (addr_q[1:0]),
    .wdata     (wdata_q),
    .mem_rdata (mem_rdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .load_data (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_q    <= LB;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      cnt_q   <= 16'h0;
      fault_q <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
            cnt_q   <= 16'h0;
            if (is_misaligned(op, addr[1:0])) begin
              fault_q <= 1'b1;
              state   <= ST_DONE;
            end else begin
              fault_q <= 1'b0;
              state   <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          // A grant is not completion, so the limit wins over a last-cycle grant.
          if (cnt_q == CNT_LAST) begin
            fault_q <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 16'h1;
            if (mem_gnt) state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Response checked first so an rvalid on the limit cycle completes cleanly.
          if (mem_rvalid) begin
            if (!is_store(op_q)) rdata_q <= load_data;
            fault_q <= 1'b0;
            state   <= ST_DONE;
          end else if (cnt_q == CNT_LAST) begin
            fault_q <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + 16'h1;
          end
        end
        default: begin
          fault_q <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Request channel is zero outside REQ, which also gives clean reset values.
  assign req_active = (state == ST_REQ);
  assign mem_req    = req_active;
  assign mem_we     = req_active && is_store(op_q);
  assign mem_addr   = req_active ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_be     = req_active ? be : 4'b0000;
  assign mem_wdata  = (req_active && is_store(op_q)) ? wdata_rep : 32'h0;

  assign stall = ((state == ST_IDLE) && start) || (state == ST_REQ) || (state == ST_WAIT);
  assign done  = (state == ST_DONE);
  assign fault = fault_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  mem_op_e     op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic        done;
  logic        fault;
  logic [31:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  // Observations captured by access()
  logic        saw_req;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  int          req_cycles;
  int          stall_cycles;
  int          done_at;
  logic        got_fault;
  logic [31:0] got_rdata;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .done       (done),
    .fault      (fault),
    .rdata      (rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs one instruction. gnt_dly = number of REQ cycles before the grant (-1: never).
  // rvalid follows the grant by one cycle. Inputs change on the falling edge.
  task automatic access(input mem_op_e o, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input int gnt_dly);
    logic pending;
    pending      = 1'b0;
    saw_req      = 1'b0;
    req_we       = 1'b0;
    req_addr     = 32'h0;
    req_be       = 4'h0;
    req_wdata    = 32'h0;
    req_cycles   = 0;
    stall_cycles = 0;
    done_at      = -1;
    got_fault    = 1'b0;
    got_rdata    = 32'h0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start      = (i == 0);
      op         = o;
      addr       = a;
      wdata      = wd;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = 32'h0;
      #1;
      if (pending) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        pending    = 1'b0;
      end
      if (mem_req) begin
        if (!saw_req) begin
          req_we    = mem_we;
          req_addr  = mem_addr;
          req_be    = mem_be;
          req_wdata = mem_wdata;
        end
        saw_req = 1'b1;
        if (req_cycles == gnt_dly) begin
          mem_gnt = 1'b1;
          pending = 1'b1;
        end
        req_cycles++;
      end
      if (stall) stall_cycles++;
      if (done) begin
        done_at   = i;
        got_fault = fault;
        got_rdata = rdata;
        break;
      end
    end
    @(negedge clk);
    start      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    #1;
    chk("done_one_cycle", {31'h0, done}, 32'h0);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    op         = LB;
    addr       = 32'h0;
    wdata      = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_stall",     {31'h0, stall},   32'h0);
    chk("rst_done",      {31'h0, done},    32'h0);
    chk("rst_fault",     {31'h0, fault},   32'h0);
    chk("rst_mem_req",   {31'h0, mem_req}, 32'h0);
    chk("rst_mem_we",    {31'h0, mem_we},  32'h0);
    chk("rst_mem_addr",  mem_addr,         32'h0);
    chk("rst_mem_be",    {28'h0, mem_be},  32'h0);
    chk("rst_mem_wdata", mem_wdata,        32'h0);
    chk("rst_rdata",     rdata,            32'h0);
    start = 1'b1;
    #1;
    chk("rst_stall_follows_start", {31'h0, stall}, 32'h1);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // 1: SW aligned, minimum latency
    access(SW, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);
    chk("sw_be",     {28'h0, req_be}, 32'h0000_000F);
    chk("sw_we",     {31'h0, req_we}, 32'h1);
    chk("sw_wdata",  req_wdata,       32'hDEAD_BEEF);
    chk("sw_addr",   req_addr,        32'h0000_0100);
    chk("sw_stall",  stall_cycles,    32'd3);
    chk("sw_done_at", done_at,        32'd3);
    chk("sw_fault",  {31'h0, got_fault}, 32'h0);

    // 2: LB sign extension, LBU zero extension
    access(LB, 32'h0000_0103, 32'h0, 32'h8011_2233, 0);
    chk("lb_be",    {28'h0, req_be}, 32'h0000_0008);
    chk("lb_we",    {31'h0, req_we}, 32'h0);
    chk("lb_wdata", req_wdata,       32'h0);
    chk("lb_addr",  req_addr,        32'h0000_0100);
    chk("lb_rdata", got_rdata,       32'hFFFF_FF80);
    chk("lb_fault", {31'h0, got_fault}, 32'h0);
    access(LBU, 32'h0000_0103, 32'h0, 32'h8011_2233, 0);
    chk("lbu_rdata", got_rdata, 32'h0000_0080);

    // Halfword loads on the upper half
    access(LH, 32'h0000_0002, 32'h0, 32'h8011_2233, 1);
    chk("lh_be",    {28'h0, req_be}, 32'h0000_000C);
    chk("lh_rdata", got_rdata,       32'hFFFF_8011);
    chk("lh_done_at", done_at,       32'd4);
    access(LHU, 32'h0000_0002, 32'h0, 32'h8011_2233, 0);
    chk("lhu_rdata", got_rdata, 32'h0000_8011);

    // 3: SH at offset 2, and SB lane replication; stores leave rdata alone
    access(SH, 32'h0000_0002, 32'h0000_ABCD, 32'h5555_5555, 0);
    chk("sh_be",    {28'h0, req_be}, 32'h0000_000C);
    chk("sh_wdata", req_wdata,       32'hABCD_ABCD);
    chk("sh_rdata_kept", got_rdata,  32'h0000_8011);
    access(SB, 32'h0000_0011, 32'h1234_56A5, 32'h0, 0);
    chk("sb_be",    {28'h0, req_be}, 32'h0000_0002);
    chk("sb_wdata", req_wdata,       32'hA5A5_A5A5);
    chk("sb_addr",  req_addr,        32'h0000_0010);

    // 4: misaligned accesses
    access(LW, 32'h0000_0101, 32'h0, 32'h0, 0);
    chk("mis_lw_req",   {31'h0, saw_req},   32'h0);
    chk("mis_lw_stall", stall_cycles,       32'd1);
    chk("mis_lw_done_at", done_at,          32'd1);
    chk("mis_lw_fault", {31'h0, got_fault}, 32'h1);
    access(LH, 32'h0000_0003, 32'h0, 32'h0, 0);
    chk("mis_lh_req",   {31'h0, saw_req},   32'h0);
    chk("mis_lh_fault", {31'h0, got_fault}, 32'h1);
    chk("mis_lh_rdata", got_rdata,          32'h0000_8011);

    // 5: timeout with no grant, then a late grant in IDLE
    access(LW, 32'h0000_0200, 32'h0, 32'h0, -1);
    chk("to_req_cycles", req_cycles,         32'd4);
    chk("to_done_at",    done_at,            32'd5);
    chk("to_fault",      {31'h0, got_fault}, 32'h1);
    chk("to_rdata",      got_rdata,          32'h0000_8011);
    @(negedge clk);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    #1;
    chk("late_gnt_req",   {31'h0, mem_req}, 32'h0);
    chk("late_gnt_stall", {31'h0, stall},   32'h0);
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    #1;
    chk("late_gnt_done", {31'h0, done}, 32'h0);

    // 6: reset during WAIT, then recovery
    @(negedge clk);
    start = 1'b1;
    op    = LW;
    addr  = 32'h0000_0300;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("rw_in_req", {31'h0, mem_req}, 32'h1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk("rw_in_wait_stall", {31'h0, stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rw_rst_req",   {31'h0, mem_req}, 32'h0);
    chk("rw_rst_stall", {31'h0, stall},   32'h0);
    chk("rw_rst_rdata", rdata,            32'h0);
    chk("rw_rst_be",    {28'h0, mem_be},  32'h0);
    @(negedge clk);
    rst_n      = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("rw_stale_rvalid_done",  {31'h0, done}, 32'h0);
    chk("rw_stale_rvalid_rdata", rdata,         32'h0);

    // Grant on the third REQ cycle; rvalid then lands on the limit cycle and must complete
    access(LW, 32'h0000_0200, 32'h0, 32'h1234_5678, 2);
    chk("rec_req_cycles", req_cycles,         32'd3);
    chk("rec_done_at",    done_at,            32'd5);
    chk("rec_stall",      stall_cycles,       32'd5);
    chk("rec_fault",      {31'h0, got_fault}, 32'h0);
    chk("rec_rdata",      got_rdata,          32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
